// File: rtl/fmc_pkg.sv
// Shared types and constants for the FMC register-bank controller.
package fmc_pkg;

  localparam int          REG_DEPTH = 64;
  localparam int          AW        = $clog2(REG_DEPTH);
  localparam logic [15:0] OOR_RDATA = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE,
    FMC_WR,
    FMC_RD,
    FMC_RDLAT,
    INT_WR,
    INT_RD,
    INT_RDLAT
  } state_e;

endpackage

// File: rtl/fmc_strobe_sync.sv
// Multi-flop synchronizer plus edge detector for one active-low FMC strobe.
// Flops reset to the idle (high) level so leaving reset never looks like an edge.
module fmc_strobe_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strb_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;

  always_comb begin
    sync_d = SYNC_STG'({sync_q, strb_i});
    prev_d = sync_q[SYNC_STG-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STG-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/fmc_bus_ctrl.sv
// Arbitrates an asynchronous FMC host and an internal master onto one register bank.
// Optional FMC_ADDR_CHECK_EN: reject FMC addresses >= REG_DEPTH and count them.
module fmc_bus_ctrl #(
  parameter int REG_DEPTH = fmc_pkg::REG_DEPTH,
  parameter int AW        = fmc_pkg::AW,
  parameter int SYNC_STG  = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fmc_ne_i,
  input  logic          fmc_noe_i,
  input  logic          fmc_nwe_i,
  input  logic [24:0]   fmc_addr_i,
  input  logic [15:0]   fmc_data_i,
  output logic [15:0]   fmc_data_o,
  output logic          fmc_data_oe_o,
  input  logic          int_req_i,
  input  logic          int_we_i,
  input  logic [AW-1:0] int_addr_i,
  input  logic [15:0]   int_wdata_i,
  output logic          int_gnt_o,
  output logic [15:0]   int_rdata_o,
  output logic          int_rvalid_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [15:0]   ram_wdata_o,
  input  logic [15:0]   ram_rdata_i,
  output logic [15:0]   err_cnt_o
);
  import fmc_pkg::*;

  logic ne_s, noe_s, nwe_s, noe_fall, nwe_rise;
  logic unused_ne_rise, unused_ne_fall, unused_noe_rise, unused_nwe_fall;

  fmc_strobe_sync #(.SYNC_STG(SYNC_STG)) u_ne_sync (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(fmc_ne_i),
    .sync_o(ne_s), .rise_o(unused_ne_rise), .fall_o(unused_ne_fall));

  fmc_strobe_sync #(.SYNC_STG(SYNC_STG)) u_noe_sync (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(fmc_noe_i),
    .sync_o(noe_s), .rise_o(unused_noe_rise), .fall_o(noe_fall));

  fmc_strobe_sync #(.SYNC_STG(SYNC_STG)) u_nwe_sync (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(fmc_nwe_i),
    .sync_o(nwe_s), .rise_o(nwe_rise), .fall_o(unused_nwe_fall));

  logic wr_ev, rd_ev, addr_oor;
  assign wr_ev = nwe_rise & ~ne_s;
  assign rd_ev = noe_fall & ~ne_s;

  state_e state_q, state_d;

  logic          wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic          wr_oor_q, wr_oor_d, rd_oor_q, rd_oor_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   fmc_data_q, fmc_data_d, int_rdata_q, int_rdata_d;
  logic          oe_q, oe_d, int_rvalid_q, int_rvalid_d;
  logic          oe_allow;

  // Read data may only be driven while the host is still reading and not writing.
  assign oe_allow = ~noe_s & ~ne_s & nwe_s;

  // Pending slots: a new event in the drain cycle wins over the clear.
  always_comb begin
    wr_pend_d = wr_pend_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_oor_d  = wr_oor_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rd_oor_d  = rd_oor_q;
    if (state_q == FMC_WR)    wr_pend_d = 1'b0;
    if (state_q == FMC_RDLAT) rd_pend_d = 1'b0;
    if (wr_ev) begin
      wr_pend_d = 1'b1;
      wr_addr_d = fmc_addr_i[AW-1:0];
      wr_data_d = fmc_data_i;
      wr_oor_d  = addr_oor;
    end
    if (rd_ev) begin
      rd_pend_d = 1'b1;
      rd_addr_d = fmc_addr_i[AW-1:0];
      rd_oor_d  = addr_oor;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_pend_q)      state_d = FMC_WR;
        else if (rd_pend_q) state_d = FMC_RD;
        else if (int_req_i) state_d = int_we_i ? INT_WR : INT_RD;
      end
      FMC_RD:  state_d = FMC_RDLAT;
      INT_RD:  state_d = INT_RDLAT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    int_gnt_o   = 1'b0;
    case (state_q)
      FMC_WR: begin
        ram_en_o    = ~wr_oor_q;
        ram_we_o    = ~wr_oor_q;
        ram_addr_o  = wr_addr_q;
        ram_wdata_o = wr_data_q;
      end
      FMC_RD: begin
        ram_en_o   = ~rd_oor_q;
        ram_addr_o = rd_addr_q;
      end
      INT_WR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = int_addr_i;
        ram_wdata_o = int_wdata_i;
        int_gnt_o   = 1'b1;
      end
      INT_RD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = int_addr_i;
        int_gnt_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Read results are registered, so a reset in a *_RDLAT cycle suppresses them.
  always_comb begin
    fmc_data_d   = fmc_data_q;
    oe_d         = oe_q & oe_allow;
    int_rdata_d  = int_rdata_q;
    int_rvalid_d = 1'b0;
    if (state_q == FMC_RDLAT) begin
      fmc_data_d = rd_oor_q ? OOR_RDATA : ram_rdata_i;
      oe_d       = oe_allow;
    end
    if (state_q == INT_RDLAT) begin
      int_rdata_d  = ram_rdata_i;
      int_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_pend_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_oor_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_oor_q     <= 1'b0;
      fmc_data_q   <= '0;
      oe_q         <= 1'b0;
      int_rdata_q  <= '0;
      int_rvalid_q <= 1'b0;
    end else begin
      wr_pend_q    <= wr_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_oor_q     <= wr_oor_d;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      rd_oor_q     <= rd_oor_d;
      fmc_data_q   <= fmc_data_d;
      oe_q         <= oe_d;
      int_rdata_q  <= int_rdata_d;
      int_rvalid_q <= int_rvalid_d;
    end
  end

  assign fmc_data_o    = fmc_data_q;
  assign fmc_data_oe_o = oe_q & oe_allow;
  assign int_rdata_o   = int_rdata_q;
  assign int_rvalid_o  = int_rvalid_q;

`ifdef FMC_ADDR_CHECK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  assign addr_oor = ({7'd0, fmc_addr_i} >= 32'(REG_DEPTH));

  // One count per rejected access, taken in the cycle that would have used the bank.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (((state_q == FMC_WR) && wr_oor_q) || ((state_q == FMC_RDLAT) && rd_oor_q))
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_addr_hi;
  assign addr_oor       = 1'b0;
  assign err_cnt_o      = '0;
  assign unused_addr_hi = ^{fmc_addr_i[24:AW], REG_DEPTH[0]};
`endif

endmodule

// File: tb/tb_fmc_bus_ctrl.sv
// Directed, table-driven bench for fmc_bus_ctrl with a behavioural 1-cycle register bank.
module tb_fmc_bus_ctrl;

  localparam int SYNC_STG = 2;
  localparam int AW       = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          fmc_ne, fmc_noe, fmc_nwe;
  logic [24:0]   fmc_addr;
  logic [15:0]   fmc_wdata;
  logic [15:0]   fmc_data_o;
  logic          fmc_data_oe_o;
  logic          int_req, int_we;
  logic [AW-1:0] int_addr;
  logic [15:0]   int_wdata;
  logic          int_gnt_o;
  logic [15:0]   int_rdata_o;
  logic          int_rvalid_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [15:0]   ram_wdata_o;
  logic [15:0]   ram_rdata;
  logic [15:0]   err_cnt_o;

  fmc_bus_ctrl #(.REG_DEPTH(64), .AW(AW), .SYNC_STG(SYNC_STG)) dut (
    .clk_i(clk), .rst_i(rst),
    .fmc_ne_i(fmc_ne), .fmc_noe_i(fmc_noe), .fmc_nwe_i(fmc_nwe),
    .fmc_addr_i(fmc_addr), .fmc_data_i(fmc_wdata),
    .fmc_data_o(fmc_data_o), .fmc_data_oe_o(fmc_data_oe_o),
    .int_req_i(int_req), .int_we_i(int_we), .int_addr_i(int_addr),
    .int_wdata_i(int_wdata), .int_gnt_o(int_gnt_o),
    .int_rdata_o(int_rdata_o), .int_rvalid_o(int_rvalid_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata), .err_cnt_o(err_cnt_o));

  always #5 clk = ~clk;

  // Register bank plus bus monitor, sampled at the active edge.
  logic [15:0]   mem [64];
  int            cyc = 0, en_cnt = 0, we_cnt = 0, we_cyc = 0;
  logic [AW-1:0] we_addr;
  logic [15:0]   we_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en_o) begin
      en_cnt    <= en_cnt + 1;
      ram_rdata <= mem[ram_addr_o];
    end
    if (ram_en_o && ram_we_o) begin
      mem[ram_addr_o] <= ram_wdata_o;
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr_o;
      we_data <= ram_wdata_o;
      we_cyc  <= cyc;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fmc_write(input logic [24:0] a, input logic [15:0] d,
                           input logic [AW-1:0] exp_addr, input logic [15:0] exp_data,
                           input int exp_cnt, input string nm);
    int w0, c0, lat;
    w0 = we_cnt;
    @(negedge clk); fmc_ne = 1'b0; fmc_addr = a; fmc_wdata = d; fmc_nwe = 1'b0;
    repeat (3) @(negedge clk);
    fmc_nwe = 1'b1; c0 = cyc;
    repeat (SYNC_STG + 6) @(negedge clk);
    fmc_ne = 1'b1;
    @(negedge clk);
    chk({nm, "_we_cnt"}, we_cnt - w0, exp_cnt);
    if (exp_cnt == 1) begin
      lat = we_cyc - c0;
      chk({nm, "_we_addr"}, {26'd0, we_addr}, {26'd0, exp_addr});
      chk({nm, "_we_data"}, {16'd0, we_data}, {16'd0, exp_data});
      chk({nm, "_latency_ok"}, {31'd0, (lat >= 1 && lat <= SYNC_STG + 4)}, 1);
    end
  endtask

  task automatic fmc_read(input logic [24:0] a, input logic [15:0] exp, input string nm);
    int k;
    @(negedge clk); fmc_ne = 1'b0; fmc_addr = a;
    @(negedge clk); fmc_noe = 1'b0;
    k = 0;
    while (!fmc_data_oe_o && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_oe"}, {31'd0, fmc_data_oe_o}, 1);
    chk({nm, "_rdata"}, {16'd0, fmc_data_o}, {16'd0, exp});
    @(negedge clk);
    chk({nm, "_oe_hold"}, {31'd0, fmc_data_oe_o}, 1);
    fmc_noe = 1'b1;
    k = 0;
    while (fmc_data_oe_o && k < SYNC_STG + 1) begin @(negedge clk); k++; end
    chk({nm, "_oe_drop"}, {31'd0, fmc_data_oe_o}, 0);
    fmc_ne = 1'b1;
    @(negedge clk);
  endtask

  task automatic int_access(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                            input logic [AW-1:0] exp_addr, input logic [15:0] exp,
                            input string nm);
    int k, w0;
    w0 = we_cnt;
    @(negedge clk); int_req = 1'b1; int_we = we; int_addr = a; int_wdata = d;
    k = 0;
    while (!int_gnt_o && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_gnt"}, {31'd0, int_gnt_o}, 1);
    int_req = 1'b0;
    if (we) begin
      @(negedge clk);
      chk({nm, "_we_cnt"}, we_cnt - w0, 1);
      chk({nm, "_we_addr"}, {26'd0, we_addr}, {26'd0, exp_addr});
      chk({nm, "_we_data"}, {16'd0, we_data}, {16'd0, exp});
    end else begin
      k = 0;
      while (!int_rvalid_o && k < 4) begin @(negedge clk); k++; end
      chk({nm, "_rvalid"}, {31'd0, int_rvalid_o}, 1);
      chk({nm, "_rdata"}, {16'd0, int_rdata_o}, {16'd0, exp});
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit            is_int;
    bit            we;
    logic [24:0]   addr;
    logic [15:0]   data;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, w0, gnt_cyc;
    logic all_out;
    string nm;

    vecs[0]  = '{1'b0, 1'b1, 25'd5,  16'h1234, 6'd5,  16'h1234};
    vecs[1]  = '{1'b0, 1'b1, 25'd7,  16'hBEEF, 6'd7,  16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 25'd63, 16'hFFFF, 6'd63, 16'hFFFF};
    vecs[3]  = '{1'b0, 1'b1, 25'd0,  16'h0001, 6'd0,  16'h0001};
    vecs[4]  = '{1'b0, 1'b0, 25'd7,  16'h0000, 6'd0,  16'hBEEF};
    vecs[5]  = '{1'b0, 1'b0, 25'd5,  16'h0000, 6'd0,  16'h1234};
    vecs[6]  = '{1'b0, 1'b0, 25'd63, 16'h0000, 6'd0,  16'hFFFF};
    vecs[7]  = '{1'b1, 1'b1, 25'd12, 16'hC0DE, 6'd12, 16'hC0DE};
    vecs[8]  = '{1'b1, 1'b0, 25'd12, 16'h0000, 6'd0,  16'hC0DE};
    vecs[9]  = '{1'b0, 1'b0, 25'd12, 16'h0000, 6'd0,  16'hC0DE};
    vecs[10] = '{1'b0, 1'b1, 25'd0,  16'hA5A5, 6'd0,  16'hA5A5};
    vecs[11] = '{1'b1, 1'b0, 25'd0,  16'h0000, 6'd0,  16'hA5A5};
    vecs[12] = '{1'b1, 1'b0, 25'd63, 16'h0000, 6'd0,  16'hFFFF};

    rst = 1'b1; fmc_ne = 1'b1; fmc_noe = 1'b1; fmc_nwe = 1'b1;
    fmc_addr = '0; fmc_wdata = '0;
    int_req = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;
    repeat (3) @(negedge clk);
    all_out = |{fmc_data_o, fmc_data_oe_o, int_gnt_o, int_rdata_o, int_rvalid_o,
                ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, err_cnt_o};
    chk("reset_outputs_zero", {31'd0, all_out}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      if (vecs[i].is_int)
        int_access(vecs[i].we, vecs[i].addr[AW-1:0], vecs[i].data, vecs[i].exp_addr,
                   vecs[i].exp, nm);
      else if (vecs[i].we)
        fmc_write(vecs[i].addr, vecs[i].data, vecs[i].exp_addr, vecs[i].exp, 1, nm);
      else
        fmc_read(vecs[i].addr, vecs[i].exp, nm);
    end

    // FMC write pending in the same idle cycle as an internal read request.
    w0 = we_cnt;
    @(negedge clk);
    fmc_ne = 1'b0; fmc_addr = 25'd9; fmc_wdata = 16'h9999; fmc_nwe = 1'b0;
    int_we = 1'b0; int_addr = 6'd9;
    repeat (3) @(negedge clk);
    fmc_nwe = 1'b1;
    repeat (SYNC_STG + 1) @(posedge clk);
    @(negedge clk); int_req = 1'b1;
    k = 0;
    while (!int_gnt_o && k < 20) begin @(negedge clk); k++; end
    gnt_cyc = cyc;
    int_req = 1'b0;
    chk("arb_gnt", {31'd0, int_gnt_o}, 1);
    chk("arb_fmc_we_cnt", we_cnt - w0, 1);
    chk("arb_fmc_we_addr", {26'd0, we_addr}, 32'd9);
    chk("arb_gnt_after_idle", gnt_cyc - we_cyc, 2);
    k = 0;
    while (!int_rvalid_o && k < 4) begin @(negedge clk); k++; end
    chk("arb_rvalid", {31'd0, int_rvalid_o}, 1);
    chk("arb_rdata_new", {16'd0, int_rdata_o}, 32'h9999);
    fmc_ne = 1'b1;
    repeat (2) @(negedge clk);

    // Reset landing in INT_RDLAT must swallow the read result.
    @(negedge clk); int_req = 1'b1; int_we = 1'b0; int_addr = 6'd7;
    k = 0;
    while (!int_gnt_o && k < 20) begin @(negedge clk); k++; end
    int_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdlat_no_rvalid", {31'd0, int_rvalid_o}, 0);
    all_out = |{fmc_data_o, fmc_data_oe_o, int_gnt_o, int_rdata_o, int_rvalid_o,
                ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, err_cnt_o};
    chk("rst_rdlat_outputs_zero", {31'd0, all_out}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdlat_still_no_rvalid", {31'd0, int_rvalid_o}, 0);
    int_access(1'b0, 6'd7, 16'h0, 6'd0, 16'hBEEF, "post_rst_int_rd");

`ifdef FMC_ADDR_CHECK_EN
    w0 = en_cnt;
    fmc_write(25'd100, 16'h5A5A, 6'd0, 16'h0, 0, "oor_wr");
    fmc_read(25'd100, 16'hDEAD, "oor_rd");
    chk("oor_no_ram_cycle", en_cnt - w0, 0);
    chk("oor_err_cnt", {16'd0, err_cnt_o}, 32'd2);
`else
    fmc_write(25'd100, 16'h5A5A, 6'd36, 16'h5A5A, 1, "trunc_wr");
    fmc_read(25'd36, 16'h5A5A, "trunc_rd36");
    fmc_read(25'd100, 16'h5A5A, "trunc_rd100");
    chk("trunc_err_cnt_zero", {16'd0, err_cnt_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmc_bus_ctrl.md
FMC_BUS_CTRL -- requirements
Module: fmc_bus_ctrl

Interface
REQ-001 The block SHALL have parameter REG_DEPTH, default 64, the number of 16-bit words in the shared register bank.
REQ-002 The block SHALL have parameter AW, default 6, the register-bank address width (clog2 of REG_DEPTH).
REQ-003 The block SHALL have parameter SYNC_STG, default 2, the number of synchronizer flops on each FMC strobe.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- fmc_ne_i  in  1  FMC chip select, active-low, asynchronous.
- fmc_noe_i  in  1  FMC output enable, active-low, asynchronous.
- fmc_nwe_i  in  1  FMC write enable, active-low, asynchronous.
- fmc_addr_i  in  25  FMC word address.
- fmc_data_i  in  16  FMC write data.
- fmc_data_o  out  16  FMC read data.
- fmc_data_oe_o  out  1  tristate enable for the FMC data pins.
- int_req_i  in  1  internal access request, held until granted.
- int_we_i  in  1  internal access type: 1 = write, 0 = read.
- int_addr_i  in  AW  internal access address.
- int_wdata_i  in  16  internal write data.
- int_gnt_o  out  1  one-cycle grant pulse.
- int_rdata_o  out  16  internal read data.
- int_rvalid_o  out  1  one-cycle pulse qualifying int_rdata_o.
- ram_en_o  out  1  register-bank port enable.
- ram_we_o  out  1  register-bank write enable.
- ram_addr_o  out  AW  register-bank address.
- ram_wdata_o  out  16  register-bank write data.
- ram_rdata_i  in  16  register-bank read data, 1-cycle read latency.
- err_cnt_o  out  16  count of out-of-range FMC accesses.

Function
REQ-005 Each of ne, noe and nwe SHALL pass through SYNC_STG flops before use; all edge detection SHALL use the synchronized values.
REQ-006 An FMC write event SHALL be a synchronized nwe rising edge while synchronized ne is low; on that cycle fmc_addr_i and fmc_data_i SHALL be captured into a single pending-write slot.
REQ-007 An FMC read event SHALL be a synchronized noe falling edge while synchronized ne is low; on that cycle fmc_addr_i SHALL be captured into a pending-read slot.
REQ-008 The FSM SHALL have the states IDLE, FMC_WR, FMC_RD, FMC_RDLAT, INT_WR, INT_RD and INT_RDLAT.
REQ-009 From IDLE, the FSM SHALL take the next transition by priority: pending write -> FMC_WR; pending read -> FMC_RD; int_req_i -> INT_WR or INT_RD, according to int_we_i.
REQ-010 In FMC_WR the block SHALL assert ram_en_o and ram_we_o for one cycle with the captured address and data, clear the pending write, and return to IDLE.
REQ-011 In FMC_RD the block SHALL assert ram_en_o with ram_we_o low and go to FMC_RDLAT.
REQ-012 In FMC_RDLAT the block SHALL register ram_rdata_i into fmc_data_o, set fmc_data_oe_o, clear the pending read, and return to IDLE.
REQ-013 fmc_data_oe_o SHALL be cleared on the first cycle in which synchronized noe or ne is high, and SHALL never be set while synchronized nwe is low.
REQ-014 int_gnt_o SHALL pulse on the cycle of entry into INT_WR or INT_RD.
REQ-015 INT_WR SHALL perform a one-cycle RAM write and return to IDLE.
REQ-016 INT_RD SHALL perform a RAM read; INT_RDLAT SHALL drive int_rdata_o from ram_rdata_i, pulse int_rvalid_o, and return to IDLE.
REQ-017 FMC events arriving during an internal access SHALL be held in their pending slots, never dropped; a second write event before the slot drains SHALL overwrite the slot (last write wins).
REQ-018 If an FMC event and int_req_i are present in the same IDLE cycle, the FMC event SHALL win.
REQ-019 ram_en_o and ram_we_o SHALL be low in every state not named above as asserting them.
REQ-020 Worst-case FMC write latency from the synchronized nwe edge to ram_we_o SHALL be 4 cycles.

Reset
REQ-021 While rst_i is high at a clock edge, the FSM SHALL go to IDLE, all pending slots and edge detectors SHALL be cleared, and every output SHALL be 0.
REQ-022 On assertion of rst_i mid-operation, an in-flight internal read SHALL produce no int_rvalid_o.

Configuration
REQ-023 With FMC_ADDR_CHECK_EN defined, an FMC address >= REG_DEPTH SHALL be treated as out of range.
REQ-024 With FMC_ADDR_CHECK_EN defined, an out-of-range write SHALL be dropped with no RAM cycle.
REQ-025 With FMC_ADDR_CHECK_EN defined, an out-of-range read SHALL return 16'hDEAD with no RAM cycle.
REQ-026 With FMC_ADDR_CHECK_EN defined, each out-of-range access SHALL increment err_cnt_o, which saturates at 16'hFFFF.
REQ-027 Without FMC_ADDR_CHECK_EN, the address SHALL be truncated to AW bits and err_cnt_o SHALL be tied to 0.

Structure
REQ-028 The state enum, REG_DEPTH, AW and the 16'hDEAD constant SHALL live in the shared package fmc_pkg.
REQ-029 The strobe synchronizer plus edge detector SHALL be the sub-module fmc_strobe_sync, instanced once per strobe.

Verification
REQ-030 FMC write to address 5 with data 16'h1234 -> exactly one ram_we_o pulse with ram_addr_o=5 and ram_wdata_o=16'h1234, no more than 4 cycles after the synchronized nwe edge.
REQ-031 FMC read of address 7 while the bank holds 16'hBEEF -> fmc_data_o=16'hBEEF and fmc_data_oe_o high until noe rises, then low within SYNC_STG+1 cycles.
REQ-032 int_req_i held high while an FMC write arrives in the same cycle -> FMC write first; int_gnt_o follows after 1 idle cycle; the internal read returns the newly written data with int_rvalid_o.
REQ-033 With FMC_ADDR_CHECK_EN defined, write to address 100 then read address 100 -> no RAM cycle for either, read data 16'hDEAD, err_cnt_o=2.
REQ-034 rst_i asserted in INT_RDLAT -> no int_rvalid_o; all outputs 0 on the next cycle; FSM in IDLE.
